// File: rtl/gumnut_ctrl.sv
// gumnut_ctrl: multi-cycle fetch/decode/execute controller for the Gumnut core.
// Define GUMNUT_CTRL_INTERRUPT_EN to compile in interrupt entry, reti, enai and disi.
module gumnut_ctrl (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [11:0] imem_addr_o,
    input  logic [17:0] inst_i,
    output logic [3:0]  alu_op_o,
    output logic [2:0]  count_o,
    output logic        carry_o,
    input  logic        alu_carry_i,
    input  logic        alu_zero_i,
    output logic [2:0]  rd_sel_o,
    output logic [2:0]  rs_sel_o,
    output logic [2:0]  r2_sel_o,
    output logic        op2_imm_o,
    output logic [7:0]  imm_o,
    output logic        rf_we_o,
    output logic        wb_data_sel_o,
    output logic        dmem_stb_o,
    output logic        dmem_we_o,
    output logic        port_sel_o,
    input  logic        dmem_ack_i,
    input  logic        int_req_i,
    output logic        int_ack_o,
    output logic        sleep_o
);
    localparam int unsigned AW  = 12;
    localparam int unsigned IW  = 18;
    localparam int unsigned SD  = 8;
    localparam int unsigned SPW = 3;

    localparam logic [2:0] M_RET  = 3'd0;
    localparam logic [2:0] M_RETI = 3'd1;
    localparam logic [2:0] M_ENAI = 3'd2;
    localparam logic [2:0] M_DISI = 3'd3;
    localparam logic [2:0] M_WAIT = 3'd4;
    localparam logic [2:0] M_STBY = 3'd5;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXECUTE, MEM, WRITEBACK, INTR, SLEEP
    } state_t;

    typedef enum logic [2:0] {
        C_ALUI, C_ALUR, C_SHIFT, C_MEM, C_BRANCH, C_JUMP, C_MISC, C_NOP
    } iclass_t;

    // Leading-ones prefix decode of the instruction class.
    function automatic iclass_t classify(input logic [IW-1:0] ir);
        if (!ir[17])      return C_ALUI;
        else if (!ir[16]) return C_MEM;
        else if (!ir[15]) return C_SHIFT;
        else if (!ir[14]) return C_ALUR;
        else if (!ir[13]) return C_JUMP;
        else if (!ir[12]) return C_BRANCH;
        else if (!ir[11]) return C_MISC;
        else              return C_NOP;
    endfunction

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic            c_q, c_d, z_q, z_d;
    logic [SPW-1:0]  sp_q, sp_d, sp_dec;
    logic            push;
    logic            br_taken;
    logic [AW-1:0]   disp;
    logic [AW-1:0]   stack_q [SD];
    iclass_t         cls_q, cls_n;

    logic [3:0]      alu_op_n;
    logic [2:0]      count_n;
    logic            carry_n, op2_imm_n, rf_we_n, wb_sel_n;
    logic            stb_n, we_n, port_n, ack_n, sleep_n;
    logic [7:0]      imm_n;

`ifdef GUMNUT_CTRL_INTERRUPT_EN
    logic            ie_q, ie_d;
    logic [AW-1:0]   pc_sh_q, pc_sh_d;
    logic            c_sh_q, c_sh_d, z_sh_q, z_sh_d;
`else
    logic            int_unused;
    assign int_unused = int_req_i;
`endif

    assign cls_q  = classify(ir_q);
    assign sp_dec = sp_q - SPW'(1);
    assign disp   = {{(AW-8){ir_q[7]}}, ir_q[7:0]};

    // Next-state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        c_d      = c_q;
        z_d      = z_q;
        sp_d     = sp_q;
        push     = 1'b0;
        br_taken = 1'b0;
`ifdef GUMNUT_CTRL_INTERRUPT_EN
        ie_d     = ie_q;
        pc_sh_d  = pc_sh_q;
        c_sh_d   = c_sh_q;
        z_sh_d   = z_sh_q;
`endif
        case (ir_q[11:10])
            2'd0:    br_taken = z_q;
            2'd1:    br_taken = !z_q;
            2'd2:    br_taken = c_q;
            default: br_taken = !c_q;
        endcase

        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                ir_d    = inst_i;
                pc_d    = pc_q + AW'(1);
                state_d = EXECUTE;
            end
            EXECUTE: begin
                state_d = FETCH;
                case (cls_q)
                    C_ALUI, C_ALUR, C_SHIFT: begin
                        c_d     = alu_carry_i;
                        z_d     = alu_zero_i;
                        state_d = WRITEBACK;
                    end
                    C_MEM:    state_d = MEM;
                    C_BRANCH: if (br_taken) pc_d = pc_q + disp;
                    C_JUMP: begin
                        if (ir_q[12]) begin
                            push = 1'b1;
                            sp_d = sp_q + SPW'(1);
                        end
                        pc_d = ir_q[AW-1:0];
                    end
                    C_MISC: begin
                        case (ir_q[10:8])
                            M_RET: begin
                                sp_d = sp_dec;
                                pc_d = stack_q[sp_dec];
                            end
`ifdef GUMNUT_CTRL_INTERRUPT_EN
                            M_RETI: begin
                                pc_d = pc_sh_q;
                                c_d  = c_sh_q;
                                z_d  = z_sh_q;
                                ie_d = 1'b1;
                            end
                            M_ENAI: ie_d = 1'b1;
                            M_DISI: ie_d = 1'b0;
`endif
                            M_WAIT, M_STBY: state_d = SLEEP;
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
            // Loads return through writeback; stores and outputs are done on ack.
            MEM: if (dmem_ack_i) state_d = ir_q[14] ? FETCH : WRITEBACK;
            WRITEBACK, INTR: state_d = FETCH;
            SLEEP: state_d = SLEEP;
            default: state_d = FETCH;
        endcase

`ifdef GUMNUT_CTRL_INTERRUPT_EN
        // Interrupts are only accepted between instructions or while asleep.
        if ((state_q == FETCH || state_q == SLEEP) && ie_q && int_req_i) begin
            state_d = INTR;
            pc_sh_d = pc_q;
            c_sh_d  = c_q;
            z_sh_d  = z_q;
            ie_d    = 1'b0;
            pc_d    = AW'(1);
        end
`endif

        cls_n     = classify(ir_d);
        alu_op_n  = 4'b0000;
        count_n   = 3'd0;
        op2_imm_n = 1'b0;
        imm_n     = 8'h00;
        carry_n   = c_d;
        case (cls_n)
            C_ALUI: begin
                alu_op_n  = {1'b0, ir_d[16:14]};
                op2_imm_n = 1'b1;
                imm_n     = ir_d[7:0];
            end
            C_ALUR:  alu_op_n = {1'b0, ir_d[2:0]};
            C_SHIFT: begin
                alu_op_n = {2'b10, ir_d[1:0]};
                count_n  = ir_d[7:5];
            end
            C_MEM: begin
                op2_imm_n = 1'b1;
                imm_n     = ir_d[7:0];
                carry_n   = 1'b0;
            end
            default: ;
        endcase
        rf_we_n  = (state_d == WRITEBACK);
        wb_sel_n = rf_we_n && (cls_n == C_MEM);
        stb_n    = (state_d == MEM);
        we_n     = stb_n && ir_d[14];
        port_n   = (cls_n == C_MEM) && ir_d[15];
        ack_n    = (state_d == INTR);
        sleep_n  = (state_d == SLEEP);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= FETCH;
            pc_q          <= '0;
            ir_q          <= '0;
            c_q           <= 1'b0;
            z_q           <= 1'b0;
            sp_q          <= '0;
`ifdef GUMNUT_CTRL_INTERRUPT_EN
            ie_q          <= 1'b0;
            pc_sh_q       <= '0;
            c_sh_q        <= 1'b0;
            z_sh_q        <= 1'b0;
`endif
            imem_addr_o   <= '0;
            alu_op_o      <= '0;
            count_o       <= '0;
            carry_o       <= 1'b0;
            rd_sel_o      <= '0;
            rs_sel_o      <= '0;
            r2_sel_o      <= '0;
            op2_imm_o     <= 1'b0;
            imm_o         <= '0;
            rf_we_o       <= 1'b0;
            wb_data_sel_o <= 1'b0;
            dmem_stb_o    <= 1'b0;
            dmem_we_o     <= 1'b0;
            port_sel_o    <= 1'b0;
            int_ack_o     <= 1'b0;
            sleep_o       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            c_q           <= c_d;
            z_q           <= z_d;
            sp_q          <= sp_d;
`ifdef GUMNUT_CTRL_INTERRUPT_EN
            ie_q          <= ie_d;
            pc_sh_q       <= pc_sh_d;
            c_sh_q        <= c_sh_d;
            z_sh_q        <= z_sh_d;
`endif
            imem_addr_o   <= pc_d;
            alu_op_o      <= alu_op_n;
            count_o       <= count_n;
            carry_o       <= carry_n;
            rd_sel_o      <= ir_d[13:11];
            rs_sel_o      <= ir_d[10:8];
            r2_sel_o      <= ir_d[7:5];
            op2_imm_o     <= op2_imm_n;
            imm_o         <= imm_n;
            rf_we_o       <= rf_we_n;
            wb_data_sel_o <= wb_sel_n;
            dmem_stb_o    <= stb_n;
            dmem_we_o     <= we_n;
            port_sel_o    <= port_n;
            int_ack_o     <= ack_n;
            sleep_o       <= sleep_n;
        end
    end

    // Return stack storage; a push on a full stack overwrites the oldest entry.
    always_ff @(posedge clk_i) begin
        if (push) stack_q[sp_q] <= pc_q;
    end

endmodule
